// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [IDX_W-1:0]   req_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  // One-hot vector with only bit idx set.
  function automatic req_vec_t idx_to_onehot(req_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import arb_pkg::*;

  req_vec_t req;
  req_vec_t gnt;
  req_idx_t sel;
  logic     gnt_valid;
  logic     timeout;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set bit of vec scanning from start upward with mod-8 wrap.
// Rotates vec so start lands on bit 0, finds the lowest set bit, then adds start back.
module rr_pick8
  import arb_pkg::*;
(
  input  req_vec_t vec,
  input  req_idx_t start,
  output logic     found,
  output req_idx_t idx
);

  req_vec_t rot;
  req_idx_t enc;

  // Rotate, fixed-priority encode (lowest index wins), un-rotate.
  always_comb begin
    rot = req_vec_t'({vec, vec} >> start);
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = req_idx_t'(i);
    end
    found = |vec;
    idx   = start + enc;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared 8-input resource. Registered one-hot grant plus select
// index; the grant is held until the owner drops its request, and handoff to the next
// requester happens on the release edge with no idle cycle in between.
// Optional build macro ARB_TIMEOUT_EN: revoke the grant after MAX_HOLD busy cycles when
// another requester is waiting, pulsing timeout alongside the new grant.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  rr_arbiter8_if.slave  bus
);

  if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  arb_state_t state_q, state_d;
  req_idx_t   ptr_q, ptr_d;
  req_idx_t   owner_q, owner_d;
  req_vec_t   gnt_q, gnt_d;

  req_vec_t   pick_vec;
  req_idx_t   pick_start;
  logic       pick_found;
  req_idx_t   pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLim = 8'(MAX_HOLD);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // While busy, the owner is masked out and the scan starts just past it; when idle, scan
  // from the saved priority pointer.
  always_comb begin
    if (state_q == BUSY) begin
      pick_vec   = bus.req & ~idx_to_onehot(owner_q);
      pick_start = owner_q + 3'd1;
    end else begin
      pick_vec   = bus.req;
      pick_start = ptr_q;
    end
  end

  rr_pick8 u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: grant from idle, hold, release/handoff and optional forced revoke.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
          gnt_d   = idx_to_onehot(pick_idx);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!bus.req[owner_q]) begin
          ptr_d = owner_q + 3'd1;
          if (pick_found) begin
            owner_d = pick_idx;
            gnt_d   = idx_to_onehot(pick_idx);
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // owner_d keeps the last owner so sel does not move while idle
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q >= HoldLim && pick_found) begin
          ptr_d     = owner_q + 3'd1;
          owner_d   = pick_idx;
          gnt_d     = idx_to_onehot(pick_idx);
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, even mid-grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = owner_q;
  assign bus.gnt_valid = |gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
